// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8-bit UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking
module uart_receive #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Serial,
  output logic [7:0] Data,
  output logic       Receive_Done,
  output logic       Frame_Err,
  output logic       Parity_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t          state_q;
  logic            sync1_q, sync2_q;
  logic            rx;
  logic            rx_prev_q;
  logic [1:0]      settle_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic [7:0]      data_q;
  logic            done_q;
  logic            ferr_q;
  logic            fall;
  logic            bit_tick;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
  logic            perr_q;
`endif

  assign rx       = sync2_q;
  assign shift_d  = {rx, shift_q[7:1]};
  // Only a genuine high-to-low on Rx, seen after the synchronizer has settled, starts a frame
  assign fall     = rx_prev_q & ~rx;
  assign bit_tick = (cnt_q == BIT_M1);

  // Two-flop synchronizer; flops reset high so the line reads idle
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Serial;
      sync2_q <= sync1_q;
    end
  end

  // Edge-detect history, held low until the synchronizer has flushed its reset value so a line low across reset cannot fake a fall
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      settle_q  <= 2'd0;
      rx_prev_q <= 1'b0;
    end else begin
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      rx_prev_q <= (settle_q == 2'd3) ? rx : 1'b0;
    end
  end

  // Receive FSM with registered outputs; baud counter reloads to 0 at every sample point
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            state_q <= rx ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_bad_q <= ^{shift_q, rx};
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            data_q  <= shift_q;
            ferr_q  <= ~rx;
`ifdef UART_RX_PARITY_EN
            perr_q  <= par_bad_q;
`endif
            state_q <= rx ? IDLE : WAIT_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data         = data_q;
  assign Receive_Done = done_q;
  assign Frame_Err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Err   = perr_q;
`else
  assign Parity_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - scoreboard testbench for uart_receive
module tb_uart_receive;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + H + 10 * C;
`else
  localparam int LAT = 3 + H + 9 * C;
`endif

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Serial = 1'b1;
  logic [7:0] Data;
  logic       Receive_Done;
  logic       Frame_Err;
  logic       Parity_Err;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  uart_receive #(.CLKS_PER_BIT(C)) dut (
    .Clk(Clk),
    .reset(reset),
    .Serial(Serial),
    .Data(Data),
    .Receive_Done(Receive_Done),
    .Frame_Err(Frame_Err),
    .Parity_Err(Parity_Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge; holds one bit for C cycles
  task automatic drive_bit(input logic v);
    Serial = v;
    repeat (C) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe, input int t);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.t = t;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge Clk);
    check("drain", sb.size(), 0);
  endtask

  // Monitor: pop and compare on every Receive_Done cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (Receive_Done === 1'b1) begin
        done_cnt = done_cnt + 1;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", Data, e.d);
          check("frame_err", Frame_Err, e.fe);
          check("parity_err", Parity_Err, e.pe);
          if (e.t >= 0) check("done_cycle", cyc, e.t);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes [4];
    int prev;
    logic [7:0] b81;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'hA5;

    repeat (3) @(negedge Clk);
    check("rst_data", Data, 8'h00);
    check("rst_done", Receive_Done, 0);
    check("rst_ferr", Frame_Err, 0);
    check("rst_perr", Parity_Err, 0);
    reset = 1'b0;
    repeat (10) @(negedge Clk);

    // Single frame with latency check
    push(8'h83, 1'b0, 1'b0, cyc + LAT);
    send_frame(8'h83, 1'b1, ^8'h83);
    wait_drain();

    // Back-to-back frames
    repeat (5) @(negedge Clk);
    foreach (bytes[k]) push(bytes[k], 1'b0, 1'b0, -1);
    foreach (bytes[k]) send_frame(bytes[k], 1'b1, ^bytes[k]);
    wait_drain();
    check("b2b_count", done_cnt, 5);

    // Short glitch must not produce a frame
    prev = done_cnt;
    repeat (5) @(negedge Clk);
    Serial = 1'b0;
    repeat (4) @(negedge Clk);
    Serial = 1'b1;
    repeat (60) @(negedge Clk);
    check("glitch_nodone", done_cnt, prev);

    // Framing error followed by break, then a real frame
    prev = done_cnt;
    push(8'h3C, 1'b1, 1'b0, -1);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (40) @(negedge Clk);
    Serial = 1'b1;
    repeat (60) @(negedge Clk);
    check("ferr_one_pulse", done_cnt, prev + 1);
    check("ferr_drain", sb.size(), 0);
    push(8'h5A, 1'b0, 1'b0, -1);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_drain();

    // Reset mid-frame at data bit 4 of 0x81
    prev = done_cnt;
    repeat (5) @(negedge Clk);
    b81 = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b81[i]);
    Serial = b81[4];
    repeat (C / 2) @(negedge Clk);
    reset = 1'b1;
    #1;
    check("midrst_data", Data, 8'h00);
    check("midrst_done", Receive_Done, 0);
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    Serial = 1'b1;
    repeat (20) @(negedge Clk);
    check("midrst_nodone", done_cnt, prev);
    push(8'h42, 1'b0, 1'b0, -1);
    send_frame(8'h42, 1'b1, ^8'h42);
    wait_drain();
    check("midrst_count", done_cnt, prev + 1);

    // Line held low across reset release must not start a frame
    prev = done_cnt;
    Serial = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    repeat (200) @(negedge Clk);
    check("lowrst_nodone", done_cnt, prev);
    Serial = 1'b1;
    repeat (20) @(negedge Clk);
    push(8'h99, 1'b0, 1'b0, -1);
    send_frame(8'h99, 1'b1, ^8'h99);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    repeat (5) @(negedge Clk);
    push(8'h07, 1'b0, 1'b1, -1);
    send_frame(8'h07, 1'b1, 1'b0);
    push(8'h07, 1'b0, 1'b0, -1);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
`endif

    repeat (20) @(negedge Clk);
    check("final_queue", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, Clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port Clk, input, 1, single system clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Serial, input, 1, asynchronous UART line (idle high), driven by the Serial output of UART_Transmit.
REQ-005 SHALL have port Data, output, 8, last received byte.
REQ-006 SHALL have port Receive_Done, output, 1, one-cycle pulse per completed frame.
REQ-007 SHALL have port Frame_Err, output, 1, stop bit sampled low on the completed frame.
REQ-008 SHALL have port Parity_Err, output, 1, parity mismatch on the completed frame.

Function
REQ-009 SHALL pass Serial through a 2-flop synchronizer; only the synchronized value (Rx) is used.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-011 IDLE: Rx high-to-low transition at cycle t0 -> START, bit counter cleared.
REQ-012 START: Rx sampled at t0+H, H = floor(CLKS_PER_BIT/2); sample 1 -> IDLE (glitch, no pulse); sample 0 -> DATA.
REQ-013 DATA: bit i (0..7) sampled at t0+H+(i+1)*CLKS_PER_BIT, shifted in LSB first.
REQ-014 Without parity, stop bit sampled at t0+H+9*CLKS_PER_BIT; with parity, parity bit at that time and stop bit at t0+H+10*CLKS_PER_BIT.
REQ-015 Cycle after stop sample: Receive_Done=1 for exactly one cycle; Data, Frame_Err, Parity_Err update in that same cycle and hold until the next completed frame.
REQ-016 Receive_Done SHALL pulse for every completed frame, including errored ones; Data loaded regardless of error.
REQ-017 Stop sample 1 -> IDLE; stop sample 0 -> Frame_Err=1, then WAIT_IDLE until Rx=1, then IDLE (break does not re-trigger).
REQ-018 Falling edges of Rx outside IDLE SHALL be ignored.
REQ-019 Baud counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide, reload to 0 on each sample point, never wrap mid-bit.
REQ-020 Back-to-back frames (stop bit immediately followed by next start bit) SHALL be received without loss.

Reset
REQ-021 reset=1 SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, Data=8'h00, Receive_Done=0, Frame_Err=0, Parity_Err=0.
REQ-022 reset asserted mid-frame SHALL abandon the frame with no Receive_Done; after release, a frame starting with the next falling edge is received normally.
REQ-023 A line held low across reset release SHALL NOT start a frame until Rx returns high and falls again.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, a PARITY state between DATA and STOP checks even parity (XOR of 8 data bits and parity bit must be 0); mismatch -> Parity_Err=1 at Receive_Done.
REQ-025 Without UART_RX_PARITY_EN, no PARITY state exists, frame is 8N1, Parity_Err tied to 0.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-026 Serial frame 8'd131 (0x83) 8N1 after reset -> Data=8'h83, one Receive_Done pulse at t0+8+144+1, Frame_Err=0.
REQ-027 Loopback UART_Transmit Serial -> uart_receive, bytes 0x00, 0xFF, 0x55, 0xA5 back-to-back -> four pulses, Data matches each byte in order.
REQ-028 Serial low for 4 cycles then high -> no Receive_Done, state returns IDLE.
REQ-029 Frame 0x3C with stop bit 0, line held low 40 cycles then high -> Receive_Done with Frame_Err=1; no second pulse until the next real frame.
REQ-030 reset asserted at data bit 4 of frame 0x81, released, then frame 0x42 sent -> no pulse for 0x81, Data=8'h42 with one pulse.
REQ-031 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> Parity_Err=1; with parity bit 1 -> Parity_Err=0.
